// File: rtl/qcl_counter_underflow_bank.sv
// qcl_counter_underflow_bank
// Bank of els_p independent down-counters (timers). Each channel supports:
//   - load via set_i, which also captures the reload mode
//   - enable via en_i
//   - one-shot or auto-reload operation
//   - saturation at zero
// Expiries are latched per channel and reported lowest-index-first through a
// valid/yumi event port. A sticky overrun flag records a lost event.
//
// Ports:
//   clk_i, reset_n_i   clock and synchronous active-low reset
//   set_i, val_i       per-channel load strobe and packed load values
//   reload_i           mode captured on set (1 = auto-reload, 0 = one-shot)
//   en_i               per-channel count enable
//   count_o, zero_o    current count (packed like val_i) and count==0 flags
//   expire_o           one-cycle expiry pulse
//   overrun_o          sticky: expiry while the channel was already pending
//   ev_v_o, ev_id_o    pending event valid and lowest pending channel index
//   ev_yumi_i          consumes the event at ev_id_o
module qcl_counter_underflow_bank #(
    parameter int unsigned width_p = 16,
    parameter int unsigned els_p   = 4,
    localparam int unsigned id_width_lp = (els_p == 1) ? 1 : $clog2(els_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic [els_p-1:0]           set_i,
    input  logic [els_p*width_p-1:0]   val_i,
    input  logic [els_p-1:0]           reload_i,
    input  logic [els_p-1:0]           en_i,
    output logic [els_p*width_p-1:0]   count_o,
    output logic [els_p-1:0]           zero_o,
    output logic [els_p-1:0]           expire_o,
    output logic [els_p-1:0]           overrun_o,
    output logic                       ev_v_o,
    output logic [id_width_lp-1:0]     ev_id_o,
    input  logic                       ev_yumi_i
);

    logic [els_p-1:0][width_p-1:0] count_q,  count_d;
    logic [els_p-1:0][width_p-1:0] period_q, period_d;
    logic [els_p-1:0]              mode_q,   mode_d;
    logic [els_p-1:0]              armed_q,  armed_d;
    logic [els_p-1:0]              pend_q,   pend_d;
    logic [els_p-1:0]              ovr_q,    ovr_d;
    logic [els_p-1:0]              expire_q, expire_d;

    logic [els_p-1:0][width_p-1:0] val;
    logic [els_p-1:0]              yumi_hit;
    logic [id_width_lp-1:0]        ev_id;

    assign val = val_i;

    // Fixed-priority encode of pending events, lowest index wins
    always_comb begin
        ev_id = '0;
        for (int i = els_p - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                ev_id = id_width_lp'(i);
            end
        end
    end

    // Yumi without a valid event is ignored
    always_comb begin
        yumi_hit = '0;
        for (int i = 0; i < els_p; i++) begin
            yumi_hit[i] = ev_yumi_i && (|pend_q) && (ev_id == id_width_lp'(i));
        end
    end

    // Per-channel next-state: set beats count; an expiry re-pends after a consume
    always_comb begin
        count_d  = count_q;
        period_d = period_q;
        mode_d   = mode_q;
        armed_d  = armed_q;
        pend_d   = pend_q;
        ovr_d    = ovr_q;
        expire_d = '0;
        for (int i = 0; i < els_p; i++) begin
            if (yumi_hit[i]) begin
                pend_d[i] = 1'b0;
            end
            if (set_i[i]) begin
                count_d[i]  = val[i];
                period_d[i] = val[i];
                mode_d[i]   = reload_i[i];
                armed_d[i]  = (val[i] != '0);
                ovr_d[i]    = 1'b0;
            end else if (en_i[i] && armed_q[i]) begin
                if (count_q[i] > width_p'(1)) begin
                    count_d[i] = count_q[i] - width_p'(1);
                end else if (count_q[i] == width_p'(1)) begin
                    expire_d[i] = 1'b1;
                    pend_d[i]   = 1'b1;
                    if (mode_q[i]) begin
                        count_d[i] = period_q[i];
                    end else begin
                        count_d[i] = '0;
                        armed_d[i] = 1'b0;
                    end
                    if (pend_q[i] && !yumi_hit[i]) begin
                        ovr_d[i] = 1'b1;
                    end
                end
            end
        end
    end

    // State registers
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            count_q  <= '0;
            period_q <= '0;
            mode_q   <= '0;
            armed_q  <= '0;
            pend_q   <= '0;
            ovr_q    <= '0;
            expire_q <= '0;
        end else begin
            count_q  <= count_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            armed_q  <= armed_d;
            pend_q   <= pend_d;
            ovr_q    <= ovr_d;
            expire_q <= expire_d;
        end
    end

    // Zero flags decoded from the count register
    always_comb begin
        zero_o = '0;
        for (int i = 0; i < els_p; i++) begin
            zero_o[i] = (count_q[i] == '0);
        end
    end

    assign count_o   = count_q;
    assign expire_o  = expire_q;
    assign overrun_o = ovr_q;
    assign ev_v_o    = |pend_q;
    assign ev_id_o   = ev_id;

endmodule

// File: tb/tb_qcl_counter_underflow_bank.sv
// Directed testbench for qcl_counter_underflow_bank (els_p=4, width_p=16).
module tb_qcl_counter_underflow_bank;

    localparam int unsigned W = 16;
    localparam int unsigned N = 4;

    logic           clk_i = 1'b0;
    logic           reset_n_i;
    logic [N-1:0]   set_i;
    logic [N*W-1:0] val_i;
    logic [N-1:0]   reload_i;
    logic [N-1:0]   en_i;
    logic [N*W-1:0] count_o;
    logic [N-1:0]   zero_o;
    logic [N-1:0]   expire_o;
    logic [N-1:0]   overrun_o;
    logic           ev_v_o;
    logic [1:0]     ev_id_o;
    logic           ev_yumi_i;

    int n_tests = 0;
    int n_fail  = 0;

    qcl_counter_underflow_bank #(.width_p(W), .els_p(N)) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .set_i     (set_i),
        .val_i     (val_i),
        .reload_i  (reload_i),
        .en_i      (en_i),
        .count_o   (count_o),
        .zero_o    (zero_o),
        .expire_o  (expire_o),
        .overrun_o (overrun_o),
        .ev_v_o    (ev_v_o),
        .ev_id_o   (ev_id_o),
        .ev_yumi_i (ev_yumi_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (reset_n_i === 1'b1 && ev_yumi_i === 1'b1) begin
            assert (ev_v_o === 1'b1)
            else $error("FAIL yumi_without_valid got ev_v=%b exp 1", ev_v_o);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [W-1:0] cnt(input int ch);
        return count_o[ch*W +: W];
    endfunction

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_count"},   64'(count_o),   64'h0);
        check_eq({tag, "_zero"},    64'(zero_o),    64'hf);
        check_eq({tag, "_expire"},  64'(expire_o),  64'h0);
        check_eq({tag, "_overrun"}, 64'(overrun_o), 64'h0);
        check_eq({tag, "_ev_v"},    64'(ev_v_o),    64'h0);
        check_eq({tag, "_ev_id"},   64'(ev_id_o),   64'h0);
    endtask

    // Ch1 auto-reload P=4 with en toggling 1,0,1,...
    logic [W-1:0] exp_cnt1 [8] = '{16'd3, 16'd3, 16'd2, 16'd2, 16'd1, 16'd1, 16'd4, 16'd4};
    logic         exp_exp1 [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        reset_n_i = 1'b0;
        set_i     = '0;
        val_i     = '0;
        reload_i  = '0;
        en_i      = '0;
        ev_yumi_i = 1'b0;
        tick();
        tick();
        check_reset_state("reset");
        reset_n_i = 1'b1;

        // Ch0 one-shot, val=3
        set_i = 4'b0001; val_i[0 +: W] = 16'd3; reload_i = 4'b0000; en_i = 4'b0001;
        tick();
        check_eq("os_load", 64'(cnt(0)), 64'd3);
        set_i = '0;
        tick();
        check_eq("os_cnt2", 64'(cnt(0)), 64'd2);
        check_eq("os_noexp2", 64'(expire_o), 64'h0);
        tick();
        check_eq("os_cnt1", 64'(cnt(0)), 64'd1);
        tick();
        check_eq("os_cnt0", 64'(cnt(0)), 64'd0);
        check_eq("os_expire", 64'(expire_o), 64'h1);
        check_eq("os_zero", 64'(zero_o), 64'hf);
        check_eq("os_ev_v", 64'(ev_v_o), 64'h1);
        check_eq("os_ev_id", 64'(ev_id_o), 64'h0);
        for (int k = 0; k < 12; k++) begin
            tick();
            check_eq("os_sat_cnt", 64'(cnt(0)), 64'd0);
            check_eq("os_sat_exp", 64'(expire_o), 64'h0);
        end
        ev_yumi_i = 1'b1;
        tick();
        ev_yumi_i = 1'b0;
        check_eq("os_consumed", 64'(ev_v_o), 64'h0);

        // Ch1 auto-reload, val=4
        set_i = 4'b0010; val_i = '0; val_i[W +: W] = 16'd4; reload_i = 4'b0010; en_i = '0;
        tick();
        set_i = '0;
        check_eq("ar_load", 64'(cnt(1)), 64'd4);
        for (int k = 0; k < 8; k++) begin
            en_i = (k % 2 == 0) ? 4'b0010 : 4'b0000;
            tick();
            check_eq("ar_cnt", 64'(cnt(1)), 64'(exp_cnt1[k]));
            check_eq("ar_exp", 64'(expire_o[1]), 64'(exp_exp1[k]));
        end
        check_eq("ar_ev_id", 64'(ev_id_o), 64'h1);
        check_eq("ar_ev_v", 64'(ev_v_o), 64'h1);
        ev_yumi_i = 1'b1;
        tick();
        ev_yumi_i = 1'b0;
        check_eq("ar_consumed", 64'(ev_v_o), 64'h0);
        set_i = 4'b0010; val_i = '0; reload_i = 4'b0010;
        tick();
        set_i = '0;
        check_eq("ar_set0_cnt", 64'(cnt(1)), 64'd0);
        en_i = 4'b0010;
        for (int k = 0; k < 6; k++) begin
            tick();
            check_eq("ar_stop_cnt", 64'(cnt(1)), 64'd0);
            check_eq("ar_stop_exp", 64'(expire_o), 64'h0);
            check_eq("ar_stop_ev", 64'(ev_v_o), 64'h0);
        end
        en_i = '0;

        // Ch2 and ch3 expire together
        set_i = 4'b1100; val_i = '0; val_i[2*W +: W] = 16'd2; val_i[3*W +: W] = 16'd2;
        reload_i = '0;
        tick();
        set_i = '0;
        en_i = 4'b1100;
        tick();
        tick();
        en_i = '0;
        check_eq("sim_expire", 64'(expire_o), 64'hc);
        check_eq("sim_ev_id_a", 64'(ev_id_o), 64'd2);
        ev_yumi_i = 1'b1;
        tick();
        check_eq("sim_ev_id_b", 64'(ev_id_o), 64'd3);
        check_eq("sim_ev_v_b", 64'(ev_v_o), 64'h1);
        tick();
        ev_yumi_i = 1'b0;
        check_eq("sim_drained", 64'(ev_v_o), 64'h0);
        check_eq("sim_drained_id", 64'(ev_id_o), 64'h0);

        // Ch0 auto-reload P=1: overrun, clear by set, consume-vs-expiry race
        set_i = 4'b0001; val_i = '0; val_i[0 +: W] = 16'd1; reload_i = 4'b0001; en_i = '0;
        tick();
        set_i = '0;
        en_i = 4'b0001;
        tick();
        check_eq("ovr_exp1", 64'(expire_o), 64'h1);
        check_eq("ovr_none1", 64'(overrun_o), 64'h0);
        tick();
        check_eq("ovr_exp2", 64'(expire_o), 64'h1);
        check_eq("ovr_set", 64'(overrun_o), 64'h1);
        set_i = 4'b0001;
        tick();
        set_i = '0;
        check_eq("ovr_cleared", 64'(overrun_o), 64'h0);
        check_eq("ovr_set_noexp", 64'(expire_o), 64'h0);
        check_eq("ovr_pend_kept", 64'(ev_v_o), 64'h1);
        ev_yumi_i = 1'b1;
        tick();
        ev_yumi_i = 1'b0;
        en_i = '0;
        check_eq("race_exp", 64'(expire_o), 64'h1);
        check_eq("race_pend", 64'(ev_v_o), 64'h1);
        check_eq("race_noovr", 64'(overrun_o), 64'h0);
        ev_yumi_i = 1'b1;
        tick();
        ev_yumi_i = 1'b0;
        check_eq("race_drained", 64'(ev_v_o), 64'h0);

        // Set coincident with count==1 & en
        set_i = 4'b0001; val_i = '0; val_i[0 +: W] = 16'd2; reload_i = '0;
        tick();
        set_i = '0;
        en_i = 4'b0001;
        tick();
        check_eq("sc_cnt1", 64'(cnt(0)), 64'd1);
        set_i = 4'b0001; val_i[0 +: W] = 16'd5;
        tick();
        set_i = '0;
        check_eq("sc_load", 64'(cnt(0)), 64'd5);
        check_eq("sc_noexp", 64'(expire_o), 64'h0);
        check_eq("sc_noev", 64'(ev_v_o), 64'h0);

        // Reset mid-count with pending and overrun state
        set_i = 4'b1000; val_i = '0; val_i[3*W +: W] = 16'd1; reload_i = 4'b1000;
        tick();
        set_i = '0;
        check_eq("rm_cnt0_a", 64'(cnt(0)), 64'd4);
        en_i = 4'b1001;
        tick();
        check_eq("rm_exp3", 64'(expire_o), 64'h8);
        check_eq("rm_ev_id", 64'(ev_id_o), 64'd3);
        tick();
        check_eq("rm_cnt0_b", 64'(cnt(0)), 64'd2);
        check_eq("rm_ovr3", 64'(overrun_o), 64'h8);
        reset_n_i = 1'b0; set_i = 4'hf; val_i = {N{16'd7}}; en_i = 4'hf;
        tick();
        check_reset_state("rm_reset");
        reset_n_i = 1'b1; set_i = '0;
        tick();
        check_eq("rm_post_cnt", 64'(count_o), 64'h0);
        check_eq("rm_post_exp", 64'(expire_o), 64'h0);
        en_i = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
